// File: rtl/apu_pkg.sv
// Shared types and frame-step constants for the NES APU frame counter.
package apu_pkg;

  typedef enum logic {
    FRAME_4STEP = 1'b0,
    FRAME_5STEP = 1'b1
  } frame_mode_t;

  localparam int unsigned STEP1   = 32'd7457;
  localparam int unsigned STEP2   = 32'd14913;
  localparam int unsigned STEP3   = 32'd22371;
  localparam int unsigned STEP4_4 = 32'd29829;
  localparam int unsigned STEP4_5 = 32'd37281;
  localparam int unsigned IRQ_PRE = 32'd29828;

endpackage

// File: rtl/apu_frame_sequencer_if.sv
// Signal bundle between the CPU register decode and the frame sequencer.
interface apu_frame_sequencer_if;
  logic       cpu_clk_en;
  logic       wr_en;
  logic [1:0] wr_data;
  logic       status_rd;
  logic       quarter_clk;
  logic       half_clk;
  logic       frame_irq;
  logic       mode;

  modport master (
    output cpu_clk_en, wr_en, wr_data, status_rd,
    input  quarter_clk, half_clk, frame_irq, mode
  );

  modport slave (
    input  cpu_clk_en, wr_en, wr_data, status_rd,
    output quarter_clk, half_clk, frame_irq, mode
  );
endinterface

// File: rtl/apu_frame_wr_delay.sv
// $4017 write-to-reset delay: loads on a write, counts CPU cycles, pulses on expiry.
module apu_frame_wr_delay #(
  parameter int unsigned DLY_EVEN = 4,
  parameter int unsigned DLY_ODD  = 3
) (
  input  logic clk,
  input  logic rst_l,
  input  logic i_cpu_clk_en,
  input  logic i_wr_en,
  input  logic i_odd_phase,
  output logic o_expire
);

  logic [2:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_cnt <= 3'd0;
    end else if (i_wr_en) begin
      r_cnt <= i_odd_phase ? 3'(DLY_ODD) : 3'(DLY_EVEN);
    end else if (i_cpu_clk_en && (r_cnt != 3'd0)) begin
      r_cnt <= r_cnt - 3'd1;
    end
  end

  // Expiry is the CPU cycle that takes the count to zero; a fresh write supersedes it.
  assign o_expire = i_cpu_clk_en && !i_wr_en && (r_cnt == 3'd1);

endmodule

// File: rtl/apu_frame_sequencer.sv
// NES APU frame counter ($4017): CPU-cycle step sequencer with quarter/half-frame strobes.
// Optional feature macro FRAME_IRQ_EN builds the frame IRQ flag, irq_inhibit and $4015-read clear.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned WR_DLY_EVEN = 4,
  parameter int unsigned WR_DLY_ODD  = 3
) (
  input logic                  clk,
  input logic                  rst_l,
  apu_frame_sequencer_if.slave io_bus
);

  localparam logic [CNT_WIDTH-1:0] C_STEP1   = CNT_WIDTH'(STEP1);
  localparam logic [CNT_WIDTH-1:0] C_STEP2   = CNT_WIDTH'(STEP2);
  localparam logic [CNT_WIDTH-1:0] C_STEP3   = CNT_WIDTH'(STEP3);
  localparam logic [CNT_WIDTH-1:0] C_LAST4   = CNT_WIDTH'(STEP4_4);
  localparam logic [CNT_WIDTH-1:0] C_LAST5   = CNT_WIDTH'(STEP4_5);
  localparam logic [CNT_WIDTH-1:0] C_IRQ_PRE = CNT_WIDTH'(IRQ_PRE);

  frame_mode_t          r_mode;
  logic [CNT_WIDTH-1:0] r_cyc;
  logic                 r_phase;
  logic                 r_quarter;
  logic                 r_half;
  logic                 w_expire;
  logic                 w_last;
  logic                 w_wrap;
  logic                 w_exp5;
  logic [CNT_WIDTH-1:0] w_last_cyc;

  apu_frame_wr_delay #(
    .DLY_EVEN (WR_DLY_EVEN),
    .DLY_ODD  (WR_DLY_ODD)
  ) u_wr_delay (
    .clk          (clk),
    .rst_l        (rst_l),
    .i_cpu_clk_en (io_bus.cpu_clk_en),
    .i_wr_en      (io_bus.wr_en),
    .i_odd_phase  (r_phase),
    .o_expire     (w_expire)
  );

  // Step decode always uses the latched mode, even while an old cyc is still counting.
  assign w_last_cyc = (r_mode == FRAME_5STEP) ? C_LAST5 : C_LAST4;
  assign w_last     = (r_cyc == w_last_cyc);
  assign w_wrap     = (r_cyc >= w_last_cyc);
  assign w_exp5     = w_expire && (r_mode == FRAME_5STEP);

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_cyc     <= '0;
      r_phase   <= 1'b0;
      r_mode    <= FRAME_4STEP;
      r_quarter <= 1'b0;
      r_half    <= 1'b0;
    end else begin
      r_quarter <= 1'b0;
      r_half    <= 1'b0;
      if (io_bus.wr_en) begin
        r_mode <= frame_mode_t'(io_bus.wr_data[1]);
      end
      if (io_bus.cpu_clk_en) begin
        r_phase   <= ~r_phase;
        r_quarter <= (r_cyc == C_STEP1) || (r_cyc == C_STEP2) || (r_cyc == C_STEP3) ||
                     w_last || w_exp5;
        r_half    <= (r_cyc == C_STEP2) || w_last || w_exp5;
        if (w_expire || w_wrap) begin
          r_cyc <= '0;
        end else begin
          r_cyc <= r_cyc + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign io_bus.quarter_clk = r_quarter;
  assign io_bus.half_clk    = r_half;
  assign io_bus.mode        = r_mode;

`ifdef FRAME_IRQ_EN
  logic r_inhibit;
  logic r_irq;
  logic r_wrapped;
  logic w_irq_set;
  logic w_inh_wr;

  assign w_inh_wr  = io_bus.wr_en && io_bus.wr_data[0];
  // r_wrapped separates a cyc==0 reached by wrap from one reached by a write reset.
  assign w_irq_set = io_bus.cpu_clk_en && (r_mode == FRAME_4STEP) && !r_inhibit &&
                     ((r_cyc == C_IRQ_PRE) || (r_cyc == C_LAST4) || ((r_cyc == '0) && r_wrapped));

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_inhibit <= 1'b0;
      r_irq     <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      if (io_bus.wr_en) begin
        r_inhibit <= io_bus.wr_data[0];
      end
      if (io_bus.cpu_clk_en) begin
        r_wrapped <= w_wrap && !w_expire;
      end
      if (w_inh_wr) begin
        r_irq <= 1'b0;
      end else if (w_irq_set) begin
        r_irq <= 1'b1;
      end else if (io_bus.status_rd) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign io_bus.frame_irq = r_irq;
`else
  logic w_unused_irq;
  assign w_unused_irq     = io_bus.status_rd ^ io_bus.wr_data[0];
  assign io_bus.frame_irq = 1'b0;
`endif

endmodule
